pwm_duty_decoder: RTL and testbench

Receive-side counterpart of the PWM generator: measures an incoming PWM waveform built from the same frame (2^RESOLUTION_BITS ticks per period, one tick every 2^FRECUENCY_BITS clocks) and recovers the duty value the generator was programmed with. It also flags off-frequency input and stuck-at-level input. It sits between an external PWM pin and the BCD converter / display path, so a loopback of the generator output reproduces the generator's value on its own display.

---
 rtl/pwm_duty_decoder.sv | 137 +++++++++++++
 tb/tb_pwm_duty_decoder.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/pwm_duty_decoder.sv
// PWM duty decoder: measures an incoming PWM frame and recovers the duty
// value, flagging off-frequency periods and stuck-at-level input.
module pwm_duty_decoder #(
    parameter int RESOLUTION_BITS = 8,
    parameter int FRECUENCY_BITS  = 3
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       pwm_in,
    output logic [RESOLUTION_BITS-1:0] value,
    output logic                       valid,
    output logic                       period_err,
    output logic                       stuck,
    output logic                       level
);

    localparam int CW = RESOLUTION_BITS + FRECUENCY_BITS + 2;
    localparam int QW = CW - FRECUENCY_BITS + 1;

    localparam logic [CW-1:0] T_C   = CW'(1) << (RESOLUTION_BITS + FRECUENCY_BITS);
    localparam logic [CW-1:0] TOL   = CW'(1) << FRECUENCY_BITS;
    localparam logic [CW-1:0] TMO   = T_C << 1;
    localparam logic [CW-1:0] P_MAX = '1;
    localparam logic [CW-1:0] LO_OK = T_C - TOL;
    localparam logic [CW-1:0] HI_OK = T_C + TOL;
    localparam logic [CW:0]   HALF  = (CW + 1)'(TOL >> 1);
    localparam logic [RESOLUTION_BITS-1:0] VMAX = '1;

    typedef enum logic [1:0] {
        WAIT_RISE,
        HIGH,
        LOW,
        STUCK
    } state_t;

    state_t state, state_n;

    logic s1, s2, s3;
    logic rise, fall;
    logic [CW-1:0] p, p_n;
    logic [CW-1:0] h, h_n;
    logic [RESOLUTION_BITS-1:0] value_n;
    logic valid_n, err_n, stuck_n, level_n;
    logic [CW:0] h_round;
    logic [QW-1:0] q;
    logic [RESOLUTION_BITS-1:0] duty;
    logic in_tol;

    // Synchronizer plus delay flop; left unreset so a level held
    // across reset does not look like a fresh edge afterwards.
    always_ff @(posedge clk) begin
        s1 <= pwm_in;
        s2 <= s1;
        s3 <= s2;
    end

    assign rise = s2 & ~s3;
    assign fall = ~s2 & s3;

    assign h_round = {1'b0, h} + HALF;
    assign q       = h_round[CW:FRECUENCY_BITS];
    assign duty    = (q > QW'(VMAX)) ? VMAX : q[RESOLUTION_BITS-1:0];
    assign in_tol  = (p >= LO_OK) && (p <= HI_OK);

    // Next-state, counters and output updates.
    always_comb begin
        state_n = state;
        p_n     = (p == P_MAX) ? p : p + CW'(1);
        h_n     = h;
        value_n = value;
        valid_n = 1'b0;
        err_n   = period_err;
        stuck_n = stuck;
        level_n = level;
        unique case (state)
            WAIT_RISE, STUCK: begin
                if (rise) begin
                    state_n = HIGH;
                    p_n     = CW'(1);
                end
            end
            HIGH: begin
                if (fall) begin
                    h_n     = p;
                    state_n = LOW;
                end
            end
            LOW: begin
                if (rise) begin
                    state_n = HIGH;
                    p_n     = CW'(1);
                    valid_n = 1'b1;
                    stuck_n = 1'b0;
                    if (in_tol) begin
                        value_n = duty;
                        err_n   = 1'b0;
                    end else begin
                        err_n = 1'b1;
                    end
                end
            end
            default: state_n = WAIT_RISE;
        endcase
        if (state != STUCK && !rise && p == TMO) begin
            state_n = STUCK;
            stuck_n = 1'b1;
            level_n = s2;
            value_n = s2 ? VMAX : '0;
            err_n   = 1'b0;
            valid_n = 1'b1;
        end
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= WAIT_RISE;
            p          <= '0;
            h          <= '0;
            value      <= '0;
            valid      <= 1'b0;
            period_err <= 1'b0;
            stuck      <= 1'b0;
            level      <= 1'b0;
        end else begin
            state      <= state_n;
            p          <= p_n;
            h          <= h_n;
            value      <= value_n;
            valid      <= valid_n;
            period_err <= err_n;
            stuck      <= stuck_n;
            level      <= level_n;
        end
    end

endmodule

// File: tb/tb_pwm_duty_decoder.sv
// Directed bench for pwm_duty_decoder: reset, timeout, duty sweep,
// period error, stuck-high recovery and mid-measurement reset.
module tb_pwm_duty_decoder;

    logic       clk;
    logic       rst;
    logic       pwm_in;
    logic [7:0] value;
    logic       valid;
    logic       period_err;
    logic       stuck;
    logic       level;

    int ncmp = 0;
    int nerr = 0;
    int vcnt = 0;
    int base = 0;

    pwm_duty_decoder #(
        .RESOLUTION_BITS(8),
        .FRECUENCY_BITS (3)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .pwm_in    (pwm_in),
        .value     (value),
        .valid     (valid),
        .period_err(period_err),
        .stuck     (stuck),
        .level     (level)
    );

    // 10 ns clock
    always #5 clk = ~clk;

    // Count clocks with valid high; a stretched pulse inflates the count.
    always @(posedge clk) begin
        if (valid === 1'b1) vcnt <= vcnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic period(input int hi, input int lo, input int n);
        repeat (n) begin
            pwm_in = 1'b1;
            cycles(hi);
            pwm_in = 1'b0;
            cycles(lo);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_value"}, 32'(value), 0);
        chk({tag, "_valid"}, 32'(valid), 0);
        chk({tag, "_err"},   32'(period_err), 0);
        chk({tag, "_stuck"}, 32'(stuck), 0);
        chk({tag, "_level"}, 32'(level), 0);
    endtask

    initial begin
        clk    = 1'b0;
        rst    = 1'b1;
        pwm_in = 1'b0;
        cycles(5);
        chk_reset("rst0");

        // Low input from reset times out into STUCK with level 0.
        rst  = 1'b0;
        base = vcnt;
        cycles(4090);
        chk("pre_tmo_stuck", 32'(stuck), 0);
        chk("pre_tmo_valid", 32'(vcnt - base), 0);
        cycles(20);
        chk("tmo_stuck", 32'(stuck), 1);
        chk("tmo_level", 32'(level), 0);
        chk("tmo_value", 32'(value), 0);
        chk("tmo_valid", 32'(vcnt - base), 1);

        // 50% duty at nominal period.
        base = vcnt;
        period(1024, 1024, 3);
        chk("d128_value", 32'(value), 128);
        chk("d128_err",   32'(period_err), 0);
        chk("d128_stuck", 32'(stuck), 0);
        chk("d128_valid", 32'(vcnt - base), 2);

        // Duty sweep, including rounding and saturation.
        period(8, 2040, 2);
        chk("d1_value", 32'(value), 1);
        chk("d1_err",   32'(period_err), 0);
        period(2044, 4, 2);
        chk("dsat_value", 32'(value), 255);
        period(1027, 1021, 2);
        chk("d1027_value", 32'(value), 128);
        period(2040, 8, 2);
        chk("d255_value", 32'(value), 255);

        // Off-frequency period flags error and holds value.
        period(1024, 1024, 2);
        chk("re128_value", 32'(value), 128);
        base = vcnt;
        period(950, 950, 2);
        chk("perr_err",   32'(period_err), 1);
        chk("perr_value", 32'(value), 128);
        chk("perr_valid", 32'(vcnt - base), 2);
        period(1024, 1024, 2);
        chk("perr_clr", 32'(period_err), 0);
        chk("perr_clr_value", 32'(value), 128);

        // Input stuck high after a 128 measurement.
        base   = vcnt;
        pwm_in = 1'b1;
        cycles(4200);
        chk("hi_stuck", 32'(stuck), 1);
        chk("hi_level", 32'(level), 1);
        chk("hi_value", 32'(value), 255);
        chk("hi_valid", 32'(vcnt - base), 2);

        // Recover with 25% duty.
        pwm_in = 1'b0;
        cycles(100);
        base = vcnt;
        period(512, 1536, 2);
        chk("rec_stuck", 32'(stuck), 0);
        chk("rec_value", 32'(value), 64);
        chk("rec_level", 32'(level), 1);
        chk("rec_err",   32'(period_err), 0);
        chk("rec_valid", 32'(vcnt - base), 1);

        // Reset during the high phase.
        pwm_in = 1'b1;
        cycles(500);
        rst = 1'b1;
        cycles(1);
        rst = 1'b0;
        chk_reset("rst1");
        base = vcnt;
        cycles(523);
        pwm_in = 1'b0;
        cycles(1024);
        period(1024, 1024, 1);
        chk("post_rst_first", 32'(vcnt - base), 0);
        period(1024, 1024, 1);
        chk("post_rst_valid", 32'(vcnt - base), 1);
        chk("post_rst_value", 32'(value), 128);
        chk("post_rst_err",   32'(period_err), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule
